// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Brief    : Instruction prefetch queue. Fetches 16-bit words from a
//            variable-latency memory and hands them to decode. It also
//            handles redirects by flushing the queue and any in-flight fetch.
//            The optional IFQ_STATS_EN macro adds fetch and bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
`ifdef IFQ_STATS_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] bubble_count
`endif
);

    localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] C_FULL     = (PW+1)'(DEPTH);
    localparam logic [15:0] C_RESET_PC = {RESET_PC[15:1], 1'b0};

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_req;
    logic           r_drop;
    logic [15:0]    r_fetch_pc;
    logic [15:0]    r_pend_pc;
    logic [PW:0]    r_count;
    logic [PW-1:0]  r_rd;
    logic [PW-1:0]  r_wr;
    logic [31:0]    r_mem [DEPTH];

    logic           w_ack;
    logic           w_push;
    logic           w_pop;
    logic [PW:0]    w_cnt_nxt;
    logic [15:0]    w_redirect_pc;

    assign w_ack         = r_req & imem_ack;
    // Drained data and data acked in a redirect cycle never reach the queue
    assign w_push        = w_ack & ~r_drop & ~redirect & (r_state == ST_FETCH);
    assign w_pop         = (r_count != '0) & ir_ready & ~redirect;
    assign w_cnt_nxt     = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    assign w_redirect_pc = redirect_pc & 16'hFFFE;

    assign imem_req  = r_req;
    assign imem_addr = r_fetch_pc;
    assign ir_valid  = (r_count != '0);
    assign ir        = r_mem[r_rd][15:0];
    assign ir_pc     = r_mem[r_rd][31:16];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_FETCH;
            r_req      <= 1'b0;
            r_drop     <= 1'b0;
            r_fetch_pc <= C_RESET_PC;
            r_pend_pc  <= 16'h0000;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            r_count <= redirect ? '0 : w_cnt_nxt;
            if (w_push) begin
                r_mem[r_wr] <= {r_fetch_pc, imem_rdata};
                r_wr        <= r_wr + PW'(1);
            end
            if (redirect) begin
                r_rd <= r_wr;
            end else if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end

            if (redirect) begin
                // An unacked request must complete before the new PC goes out
                if (!r_req || imem_ack) begin
                    r_state    <= ST_FETCH;
                    r_req      <= 1'b1;
                    r_drop     <= 1'b0;
                    r_fetch_pc <= w_redirect_pc;
                end else begin
                    r_state    <= ST_DRAIN;
                    r_req      <= 1'b1;
                    r_drop     <= 1'b1;
                    r_pend_pc  <= w_redirect_pc;
                end
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (w_push) begin
                            r_fetch_pc <= r_fetch_pc + 16'd2;
                        end
                        if (w_cnt_nxt == C_FULL) begin
                            r_state <= ST_HOLD;
                            r_req   <= 1'b0;
                        end else begin
                            r_req   <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (w_cnt_nxt != C_FULL) begin
                            r_state <= ST_FETCH;
                            r_req   <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_ack) begin
                            r_state    <= ST_FETCH;
                            r_req      <= 1'b1;
                            r_drop     <= 1'b0;
                            r_fetch_pc <= r_pend_pc;
                        end
                    end
                    default: begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b0;
                        r_drop  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef IFQ_STATS_EN
    logic [15:0] r_fetch_count;
    logic [15:0] r_bubble_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_count  <= 16'h0000;
            r_bubble_count <= 16'h0000;
        end else begin
            if (w_push && (r_fetch_count != 16'hFFFF)) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
            if ((r_count == '0) && (r_bubble_count != 16'hFFFF)) begin
                r_bubble_count <= r_bubble_count + 16'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;
`endif

endmodule
`default_nettype wire
